// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD helpers for multi_alarm_clock.
// ALARM_SNOOZE_EN adds the SNOOZE state to the FSM encoding.
package alarm_clock_pkg;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;
  localparam int DIGIT_MAX  = 9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hm_t;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;
`else
  typedef enum logic {ST_IDLE, ST_RING} state_t;
`endif

  function automatic logic bcd_hm_valid(input hm_t v);
    return (v.h0 <= 4'(DIGIT_MAX)) && (v.m1 <= 4'(MINSEC_MAX / 10)) &&
           (v.m0 <= 4'(DIGIT_MAX)) &&
           ((int'(v.h1) * 10 + int'(v.h0)) <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with synchronous load and a strobe
// marking the cycle in which the time has just become HH:MM:00.
module bcd_time_counter
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  hm_t        load_hm,
  output logic [1:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       at_zero
);

  localparam logic [3:0] D_MAX  = 4'(DIGIT_MAX);
  localparam logic [3:0] T_MAX  = 4'(MINSEC_MAX / 10);
  localparam logic [1:0] H1_MAX = 2'(HOUR_MAX / 10);
  localparam logic [3:0] H0_MAX = 4'(HOUR_MAX % 10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 <= '0; h0 <= '0; m1 <= '0; m0 <= '0; s1 <= '0; s0 <= '0;
      at_zero <= 1'b0;
    end else begin
      at_zero <= 1'b0;
      if (load) begin
        h1 <= load_hm.h1; h0 <= load_hm.h0;
        m1 <= load_hm.m1; m0 <= load_hm.m0;
        s1 <= '0; s0 <= '0;
        at_zero <= 1'b1;
      end else if (tick) begin
        if (s0 != D_MAX) s0 <= s0 + 1'b1;
        else begin
          s0 <= '0;
          if (s1 != T_MAX) s1 <= s1 + 1'b1;
          else begin
            s1 <= '0;
            at_zero <= 1'b1;
            if (m0 != D_MAX) m0 <= m0 + 1'b1;
            else begin
              m0 <= '0;
              if (m1 != T_MAX) m1 <= m1 + 1'b1;
              else begin
                m1 <= '0;
                if (h1 == H1_MAX && h0 == H0_MAX) begin
                  h1 <= '0; h0 <= '0;
                end else if (h0 != D_MAX) h0 <= h0 + 1'b1;
                else begin
                  h0 <= '0; h1 <= h1 + 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// BCD 24h clock with N alarm channels, ring timeout and optional snooze.
// Define ALARM_SNOOZE_EN to compile in the SNOOZE state and snooze counter.
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC  = 10,
  parameter int unsigned N_ALARMS     = 4,
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned RING_MAX_MIN = 1,
  localparam int unsigned ALW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [ALW-1:0]      AL_SEL,
  input  logic [N_ALARMS-1:0] AL_EN,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  output logic                Alarm,
  output logic [ALW-1:0]      Alarm_id,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0
);

  localparam int unsigned PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned RING_TICKS = RING_MAX_MIN * 60;
  localparam int unsigned RW         = $clog2(RING_TICKS);

  logic [PW-1:0] pre;
  logic          tick;
  hm_t           load_hm;
  hm_t           cur_hm;
  logic          load_ok;
  logic          time_ld;
  logic          at_zero;
  hm_t           alarm_reg [N_ALARMS];
  logic          hit;
  logic [ALW-1:0] hit_id;

  assign load_hm = {H_in1, H_in0, M_in1, M_in0};
  assign cur_hm  = {H_out1, H_out0, M_out1, M_out0};
  assign load_ok = bcd_hm_valid(load_hm);
  assign time_ld = LD_time & load_ok;
  assign tick    = (pre == PW'(CLK_PER_SEC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              pre <= '0;
    else if (time_ld || tick) pre <= '0;
    else                    pre <= pre + 1'b1;
  end

  bcd_time_counter u_time (
    .clk     (clk),
    .rst     (reset),
    .tick    (tick),
    .load    (time_ld),
    .load_hm (load_hm),
    .h1      (H_out1),
    .h0      (H_out0),
    .m1      (M_out1),
    .m0      (M_out0),
    .s1      (S_out1),
    .s0      (S_out0),
    .at_zero (at_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_ALARMS; k++) alarm_reg[k] <= '0;
    end else if (LD_alarm && load_ok) begin
      for (int unsigned k = 0; k < N_ALARMS; k++)
        if (AL_SEL == ALW'(k)) alarm_reg[k] <= load_hm;
    end
  end

  // Lowest enabled matching channel wins
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int unsigned k = 0; k < N_ALARMS; k++) begin
      if (!hit && AL_EN[k] && alarm_reg[k] == cur_hm) begin
        hit    = 1'b1;
        hit_id = ALW'(k);
      end
    end
  end

  state_t         state, state_nx;
  logic [RW-1:0]  ring_cnt, ring_nx;
  logic [ALW-1:0] id_nx;
  logic           en_cur;

  assign en_cur = AL_EN[Alarm_id];

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned SW        = $clog2(SNZ_TICKS);
  logic [SW-1:0] snz_cnt, snz_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) snz_cnt <= '0;
    else       snz_cnt <= snz_nx;
  end
`else
  logic snooze_unused;
  assign snooze_unused = SNOOZE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ring_cnt <= '0;
      Alarm    <= 1'b0;
      Alarm_id <= '0;
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_nx;
      Alarm    <= (state_nx == ST_RING);
      Alarm_id <= id_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ring_nx  = ring_cnt;
    id_nx    = Alarm_id;
`ifdef ALARM_SNOOZE_EN
    snz_nx   = snz_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (at_zero && hit) begin
          state_nx = ST_RING;
          id_nx    = hit_id;
          ring_nx  = '0;
        end
      end
      ST_RING: begin
        if (STOP_al || !en_cur) state_nx = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (SNOOZE) begin
          state_nx = ST_SNOOZE;
          snz_nx   = '0;
        end
`endif
        else if (tick) begin
          if (ring_cnt == RW'(RING_TICKS - 1)) state_nx = ST_IDLE;
          else ring_nx = ring_cnt + 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (STOP_al || !en_cur) state_nx = ST_IDLE;
        else if (tick) begin
          if (snz_cnt == SW'(SNZ_TICKS - 1)) begin
            state_nx = ST_RING;
            ring_nx  = '0;
          end else snz_nx = snz_cnt + 1'b1;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock against a seconds-of-day model.
module tb_multi_alarm_clock;

  localparam int CPS    = 2;
  localparam int RING_T = 60;
  localparam int SNZ_T  = 300;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;
  logic       LD_time = 1'b0, LD_alarm = 1'b0, STOP_al = 1'b0, SNOOZE = 1'b0;
  logic [1:0] AL_SEL = '0;
  logic [3:0] AL_EN = '0;
  logic       Alarm;
  logic [1:0] Alarm_id;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  multi_alarm_clock #(.CLK_PER_SEC(CPS), .N_ALARMS(4), .SNOOZE_MIN(5), .RING_MAX_MIN(1)) dut (
    .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_EN(AL_EN),
    .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(Alarm), .Alarm_id(Alarm_id),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of day, alarms as minutes of day
  int m_sec = 0, m_pre = 0, m_state = 0, m_id = 0, m_ring = 0, m_snz = 0;
  bit m_fresh = 0;
  int m_alarm [4] = '{0, 0, 0, 0};

  task automatic model_reset();
    m_sec = 0; m_pre = 0; m_state = 0; m_id = 0; m_ring = 0; m_snz = 0; m_fresh = 0;
    for (int k = 0; k < 4; k++) m_alarm[k] = 0;
  endtask

  task automatic model_step();
    int hh, mm, hit;
    bit ok, tk;
    hh = int'(H_in1) * 10 + int'(H_in0);
    mm = int'(M_in1) * 10 + int'(M_in0);
    ok = (H_in0 <= 9) && (M_in1 <= 5) && (M_in0 <= 9) && (hh <= 23);
    tk = (m_pre == CPS - 1);
    hit = -1;
    if (m_fresh)
      for (int k = 0; k < 4; k++)
        if (hit < 0 && AL_EN[k] && m_alarm[k] == m_sec / 60) hit = k;
    case (m_state)
      0: if (hit >= 0) begin m_state = 1; m_id = hit; m_ring = 0; end
      1: begin
        if (STOP_al || !AL_EN[m_id]) m_state = 0;
        else if (SNZ_ON && SNOOZE) begin m_state = 2; m_snz = 0; end
        else if (tk) begin m_ring++; if (m_ring == RING_T) m_state = 0; end
      end
      default: begin
        if (STOP_al || !AL_EN[m_id]) m_state = 0;
        else if (tk) begin
          m_snz++;
          if (m_snz == SNZ_T) begin m_state = 1; m_ring = 0; end
        end
      end
    endcase
    if (LD_time && ok) begin
      m_sec = (hh * 60 + mm) * 60; m_pre = 0; m_fresh = 1;
    end else if (tk) begin
      m_sec = (m_sec + 1) % 86400; m_pre = 0; m_fresh = (m_sec % 60 == 0);
    end else begin
      m_pre++; m_fresh = 0;
    end
    if (LD_alarm && ok) m_alarm[AL_SEL] = hh * 60 + mm;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    logic [24:0] exp_v, act_v;
    int hh, mm, ss;
    hh = m_sec / 3600; mm = (m_sec / 60) % 60; ss = m_sec % 60;
    exp_v = {(m_state == 1), 2'(m_id), 2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
             4'(ss / 10), 4'(ss % 10)};
    act_v = {Alarm, Alarm_id, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp at %0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit time_is(input int h, input int m, input int s);
    return H_out1 == h / 10 && H_out0 == h % 10 && M_out1 == m / 10 &&
           M_out0 == m % 10 && S_out1 == s / 10 && S_out0 == s % 10;
  endfunction

  task automatic load_time_raw(input logic [1:0] a, input logic [3:0] b, c, d);
    H_in1 = a; H_in0 = b; M_in1 = c; M_in0 = d; LD_time = 1'b1;
    @(negedge clk); LD_time = 1'b0;
  endtask

  task automatic load_time(input int h, input int m);
    load_time_raw(2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10));
  endtask

  task automatic load_alarm_raw(input logic [1:0] sel, input logic [1:0] a,
                                input logic [3:0] b, c, d);
    AL_SEL = sel; H_in1 = a; H_in0 = b; M_in1 = c; M_in0 = d; LD_alarm = 1'b1;
    @(negedge clk); LD_alarm = 1'b0;
  endtask

  task automatic wait_alarm(input logic lvl, input int maxc, output int n);
    n = 0;
    while (Alarm !== lvl && n < maxc) begin @(negedge clk); n++; end
    if (Alarm !== lvl) begin
      checks++; errors++;
      $display("FAIL wait_alarm: got %b expected %b within %0d cycles", Alarm, lvl, maxc);
    end
  endtask

  typedef struct {
    logic [1:0] h1;
    logic [3:0] h0, m1, m0;
    bit ok;
  } ld_vec_t;

  initial begin
    ld_vec_t vec [8];
    int n, z, r, highs, tm, rr, k;
    vec[0] = '{2'd2, 4'd3, 4'd5, 4'd9, 1'b1};
    vec[1] = '{2'd2, 4'd4, 4'd0, 4'd0, 1'b0};
    vec[2] = '{2'd1, 4'd0, 4'd6, 4'd0, 1'b0};
    vec[3] = '{2'd0, 4'd9, 4'd5, 4'd9, 1'b1};
    vec[4] = '{2'd1, 4'd10, 4'd0, 4'd0, 1'b0};
    vec[5] = '{2'd3, 4'd0, 4'd0, 4'd0, 1'b0};
    vec[6] = '{2'd1, 4'd9, 4'd0, 4'd0, 1'b1};
    vec[7] = '{2'd0, 4'd0, 4'd0, 4'd15, 1'b0};

    @(negedge clk);
    chk("reset_outputs", int'({Alarm, Alarm_id, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}), 0);
    reset = 1'b0;

    // BCD rollover at midnight
    load_time(23, 59);
    repeat (4) @(negedge clk);
    chk("sec_every_2clk", int'(S_out0), 2);
    repeat (116) @(negedge clk);
    chk("midnight_wrap", int'(time_is(0, 0, 0)), 1);

    // Load validity table
    foreach (vec[i]) begin
      load_time(12, 34);
      load_time_raw(vec[i].h1, vec[i].h0, vec[i].m1, vec[i].m0);
      chk($sformatf("ld_vec%0d", i),
          int'({H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}),
          vec[i].ok ? int'({vec[i].h1, vec[i].h0, vec[i].m1, vec[i].m0, 8'h00})
                    : int'({2'd1, 4'd2, 4'd3, 4'd4, 8'h00}));
    end

    // Alarm 2 at 10:20 via rollover, then stop
    load_alarm_raw(2'd2, 2'd1, 4'd0, 4'd2, 4'd0);
    AL_EN = 4'b0100;
    load_time(10, 19);
    z = -1; r = -1;
    for (int i = 0; i < 200 && r < 0; i++) begin
      @(negedge clk);
      if (z < 0 && time_is(10, 20, 0)) z = i;
      if (Alarm) r = i;
    end
    chk("rise_after_00", (z >= 0 && r >= 0) ? r - z : -1, 1);
    chk("ring_id2", int'(Alarm_id), 2);
    STOP_al = 1'b1; @(negedge clk); STOP_al = 1'b0;
    chk("stop_drops", int'(Alarm), 0);
    highs = 0;
    repeat (100) begin @(negedge clk); highs += int'(Alarm); end
    chk("no_rering", highs, 0);

    // Two channels match: lowest wins; trigger via LD_time
    AL_EN = 4'b0000;
    load_alarm_raw(2'd1, 2'd0, 4'd7, 4'd3, 4'd0);
    load_alarm_raw(2'd3, 2'd0, 4'd7, 4'd3, 4'd0);
    AL_EN = 4'b1010;
    load_time(7, 30);
    chk("no_alarm_yet", int'(Alarm), 0);
    @(negedge clk);
    chk("prio_alarm", int'(Alarm), 1);
    chk("prio_id", int'(Alarm_id), 1);
    STOP_al = 1'b1; @(negedge clk); STOP_al = 1'b0;
    load_alarm_raw(2'd1, 2'd2, 4'd4, 4'd0, 4'd0);
    load_time_raw(2'd1, 4'd0, 4'd6, 4'd0);
    chk("bad_load_time", int'({H_out1, H_out0, M_out1, M_out0}), int'({2'd0, 4'd7, 4'd3, 4'd0}));

    // Ring auto timeout; alarm 1 still holds 07:30
    load_time(7, 30);
    wait_alarm(1'b1, 5, n);
    chk("timeout_id", int'(Alarm_id), 1);
    n = 0;
    while (Alarm && n < 300) begin n++; @(negedge clk); end
    chk("ring_len", n, RING_T * CPS - 1);

    // AL_EN cleared mid-ring
    load_time(7, 30);
    wait_alarm(1'b1, 5, n);
    repeat (5) @(negedge clk);
    AL_EN = 4'b1000;
    @(negedge clk);
    chk("en_clear_drop", int'(Alarm), 0);
    AL_EN = 4'b1010;

    load_time(7, 30);
    wait_alarm(1'b1, 5, n);
    SNOOZE = 1'b1; @(negedge clk); SNOOZE = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snooze_drop", int'(Alarm), 0);
    wait_alarm(1'b1, 800, n);
    chk("snooze_window", int'(n >= SNZ_T * CPS - CPS && n <= SNZ_T * CPS - 1), 1);
    chk("snooze_id", int'(Alarm_id), 1);
    SNOOZE = 1'b1; @(negedge clk); SNOOZE = 1'b0;
    repeat (3) @(negedge clk);
    STOP_al = 1'b1; @(negedge clk); STOP_al = 1'b0;
    highs = 0;
    repeat (700) begin @(negedge clk); highs += int'(Alarm); end
    chk("stop_in_snooze", highs, 0);
`else
    chk("snooze_ignored", int'(Alarm), 1);
    STOP_al = 1'b1; @(negedge clk); STOP_al = 1'b0;
`endif

    // Asynchronous reset mid-ring
    load_time(7, 30);
    wait_alarm(1'b1, 5, n);
    #2 reset = 1'b1;
    #1 chk("async_rst", int'({Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", int'(Alarm), 0);

    // Randomised traffic against the model
    AL_EN = 4'b1111;
    for (int i = 0; i < 4000; i++) begin
      rr = int'($urandom % 100);
      LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
      if (rr < 2) begin
        if ($urandom % 2 == 0) begin
          k = int'($urandom % 4); tm = m_alarm[k];
          H_in1 = 2'(tm / 600); H_in0 = 4'((tm / 60) % 10);
          M_in1 = 4'((tm % 60) / 10); M_in0 = 4'(tm % 10);
        end else begin
          H_in1 = 2'($urandom % 4); H_in0 = 4'($urandom % 12);
          M_in1 = 4'($urandom % 7); M_in0 = 4'($urandom % 11);
        end
        LD_time = 1'b1;
      end else if (rr < 6) begin
        tm = (m_sec / 60 + 1 + int'($urandom % 2)) % 1440;
        AL_SEL = 2'($urandom % 4);
        H_in1 = 2'(tm / 600); H_in0 = 4'((tm / 60) % 10);
        M_in1 = 4'((tm % 60) / 10); M_in0 = 4'(tm % 10);
        LD_alarm = 1'b1;
      end else if (rr < 7) AL_EN = 4'($urandom % 16);
      else if (rr < 8) STOP_al = 1'b1;
      else if (rr < 10) SNOOZE = 1'b1;
      @(negedge clk);
    end
    LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised successor to the single-alarm clock. Keeps a BCD 24-hour HH:MM:SS time-of-day driven from a system clock through a built-in seconds prescaler. Supports N independently loadable and enabled alarm channels, ring auto-timeout and optional snooze. Sits between the button/switch input logic and the 7-segment display/buzzer drivers.

## Interface
- CLK_PER_SEC, 10, clk cycles per second (>=1); prescaler period.
- N_ALARMS, 4, alarm channels (1..8); ALW = max(1, $clog2(N_ALARMS)).
- SNOOZE_MIN, 5, snooze delay in minutes (1..9).
- RING_MAX_MIN, 1, ring auto-stop after this many minutes (1..9).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- H_in1 in 2, H_in0 in 4, M_in1 in 4, M_in0 in 4  BCD load value HH:MM.
- LD_time  in  1  load time from H/M inputs.
- LD_alarm  in  1  load alarm register AL_SEL from H/M inputs.
- AL_SEL  in  ALW  alarm channel select for LD_alarm.
- AL_EN  in  N_ALARMS  per-channel alarm enable.
- STOP_al  in  1  stop ringing/snoozing alarm.
- SNOOZE  in  1  snooze request (used only with ALARM_SNOOZE_EN).
- Alarm  out  1  buzzer drive.
- Alarm_id  out  ALW  index of ringing/snoozed channel.
- H_out1 out 2, H_out0/M_out1/M_out0/S_out1/S_out0 out 4  current time, BCD.

## Operation
- Prescaler counts 0..CLK_PER_SEC-1; `tick` is asserted on the cycle it equals CLK_PER_SEC-1, then it wraps.
- On tick, time advances in BCD: S 00..59, M 00..59, H 00..23. 23:59:59 wraps to 00:00:00.
- LD_time loads HH:MM, clears seconds and the prescaler, and has priority over a same-cycle tick.
- LD_alarm writes HH:MM into alarm[AL_SEL]. AL_SEL >= N_ALARMS is ignored. LD_time and LD_alarm in the same cycle both take effect.
- Invalid load values (any digit >9, hour >23, M_in1 >5) are ignored; the target register is unchanged.
- Trigger event: the cycle in which the time register becomes HH:MM:00, by tick rollover or by LD_time, and HH:MM equals alarm[k] with AL_EN[k]=1. The lowest matching k wins.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE -> RING on a trigger. Latch k into Alarm_id, set Alarm=1, clear the ring timer.
  - RING -> IDLE on any of: STOP_al; AL_EN[Alarm_id]=0; ring timer reaching RING_MAX_MIN*60 ticks.
  - RING -> SNOOZE on SNOOZE (macro only). Alarm=0, snooze counter cleared.
  - SNOOZE -> RING after SNOOZE_MIN*60 ticks. Ring timer restarts. Alarm_id is kept.
  - SNOOZE -> IDLE on STOP_al or AL_EN[Alarm_id]=0.
- STOP_al and SNOOZE in the same cycle: STOP_al wins.
- Triggers arriving while in RING or SNOOZE are dropped.
- Snooze count is unlimited.
- Reset values: time 00:00:00, alarms 00:00, prescaler 0, state IDLE, Alarm 0, Alarm_id 0.

## Timing
- All outputs are registered. Loads are visible on the edge after the request.
- Alarm rises one cycle after the time outputs first show the matching HH:MM:00.
- STOP_al, SNOOZE and AL_EN deassertion drop Alarm on the next edge.
- Ring timeout and snooze expiry are counted in ticks from entry to the state. They are not aligned to :00.
- Reset is asynchronous: outputs take their reset values immediately. Reset mid-ring returns to IDLE.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state and the snooze counter are compiled in.
- ALARM_SNOOZE_EN undefined: the SNOOZE port remains but is ignored. The FSM has only IDLE and RING; no snooze counter is present.

## Structure
- Package alarm_clock_pkg holds:
  - FSM state enum;
  - BCD limit constants (23, 59, 9);
  - a bcd_hm_valid function shared by both load paths.
- Sub-module bcd_time_counter: HH:MM:SS BCD counter with tick input, synchronous load and rollover-to-:00 strobe output. Instantiated once.

## Test plan
- CLK_PER_SEC=2, LD_time 23:59, run 120 clocks -> outputs 00:00:00, seconds incremented every 2 clocks.
- Alarm 2 = 10:20, AL_EN=4'b0100, LD_time 10:19 -> Alarm=1 and Alarm_id=2 one cycle after 10:20:00. STOP_al -> Alarm=0 next edge; no re-ring within that minute.
- Alarms 1 and 3 both 07:30, AL_EN=4'b1010 -> Alarm_id=1. A load of 24:00 or 10:60 leaves time and alarm registers unchanged.
- With ALARM_SNOOZE_EN, SNOOZE_MIN=5: SNOOZE while ringing -> Alarm=0, re-asserts after 300 ticks with the same Alarm_id. STOP_al during SNOOZE -> stays 0. Without the macro, SNOOZE has no effect.
- RING_MAX_MIN=1, no stop -> Alarm drops after 60 ticks. Clearing AL_EN[Alarm_id] mid-ring -> Alarm=0 next edge.
- Assert reset mid-ring -> Alarm=0 and time 00:00:00 without waiting for a clock edge; state IDLE after release.
